i8080_rx_ctrl: RTL and testbench

- Upstream front end of the i8080-to-RGB bridge, in the CLK_100M domain.
- Synchronises the asynchronous i8080 write bus, detects write strobes and decodes the DCS-style command subset.
- Holds the window, backlight and display-on state.
- Streams memory-write pixel bytes into the display FIFO and issues the frame-start pulse (FrameCtrl) to the video timing stage.

---
 rtl/i8080_pkg.sv | 25 ++
 rtl/i8080_sync.sv | 43 ++++
 rtl/i8080_rx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_i8080_rx_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i8080_pkg.sv
// Shared definitions for the i8080 receive front end: command codes and control states.
package i8080_pkg;

  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;
  localparam logic [7:0] CMD_BL      = 8'h51;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_SWRST   = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PARAM  = 2'd1,
    MEMWR  = 2'd2,
    IGNORE = 2'd3
  } state_t;

  // Index of the final parameter byte for a command that takes parameters.
  function automatic logic [1:0] param_last(input logic [7:0] cmd);
    return (cmd == CMD_BL) ? 2'd0 : 2'd3;
  endfunction

endpackage

// File: rtl/i8080_sync.sv
// Brings the asynchronous i8080 write bus into the CLK domain and flags each WR rising edge
// seen while chip select is low. Outputs are registered.
module i8080_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_n_i,
  input  logic       rs_i,
  input  logic       wr_n_i,
  input  logic [7:0] d_i,
  output logic       wr_evt_o,
  output logic       rs_o,
  output logic [7:0] d_o
);

  // Bus word layout: [10] CS_n, [9] RS, [8] WR_n, [7:0] D; reset to an idle, deselected bus.
  localparam logic [10:0] BUS_IDLE = 11'b101_0000_0000;

  logic [10:0] pipe_q [SYNC_STAGES];
  logic [10:0] bus_s;
  logic        wr_prev_q;

  assign bus_s = pipe_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) pipe_q[i] <= BUS_IDLE;
      wr_prev_q <= 1'b1;
      wr_evt_o  <= 1'b0;
      rs_o      <= 1'b0;
      d_o       <= 8'h00;
    end else begin
      pipe_q[0] <= {cs_n_i, rs_i, wr_n_i, d_i};
      for (int i = 1; i < SYNC_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
      wr_prev_q <= bus_s[8];
      wr_evt_o  <= bus_s[8] & ~wr_prev_q & ~bus_s[10];
      rs_o      <= bus_s[9];
      d_o       <= bus_s[7:0];
    end
  end

endmodule

// File: rtl/i8080_rx_ctrl.sv
// i8080 write-bus front end: decodes the DCS command subset, holds window/backlight/display
// state and streams memory-write bytes to the display FIFO with frame start/done pulses.
module i8080_rx_ctrl
  import i8080_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int H_RES         = 800,
  parameter int V_RES         = 480,
  parameter int BYTES_PER_PIX = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i8080_CS,
  input  logic        i8080_RS,
  input  logic        i8080_WR,
  input  logic [7:0]  i8080_D,
  output logic        i8080_RD,
  input  logic        FIFO_FULL,
  output logic        FIFO_WE,
  output logic [7:0]  FIFO_DI,
  output logic        FrameCtrl,
  output logic        FRAME_DONE,
  output logic [15:0] COL_START,
  output logic [15:0] COL_END,
  output logic [15:0] ROW_START,
  output logic [15:0] ROW_END,
  output logic [7:0]  BL_LEVEL,
  output logic        DISP_ON,
  output logic        OVERFLOW,
  output state_t      dbg_state_o
);

  localparam int          TOTAL       = H_RES * V_RES * BYTES_PER_PIX;
  localparam int          CW          = $clog2(TOTAL);
  localparam logic [CW-1:0] LAST_BYTE = CW'(TOTAL - 1);
  localparam logic [15:0] COL_END_RST = 16'(H_RES - 1);
  localparam logic [15:0] ROW_END_RST = 16'(V_RES - 1);

  logic       wr_evt;
  logic       rs_s;
  logic [7:0] d_s;

  i8080_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i    (CLK),
    .rst_i    (RST),
    .cs_n_i   (i8080_CS),
    .rs_i     (i8080_RS),
    .wr_n_i   (i8080_WR),
    .d_i      (i8080_D),
    .wr_evt_o (wr_evt),
    .rs_o     (rs_s),
    .d_o      (d_s)
  );

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    pcmd_q;
  logic [1:0]    pidx_q;
  logic [23:0]   pbuf_q;
  logic [15:0]   col_start_q, col_end_q, row_start_q, row_end_q;
  logic [7:0]    bl_q, fifo_di_q;
  logic          disp_q, ovf_q, fifo_we_q, frame_ctrl_q, frame_done_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pcmd_q       <= 8'h00;
      pidx_q       <= 2'd0;
      pbuf_q       <= 24'h0;
      col_start_q  <= 16'h0;
      col_end_q    <= COL_END_RST;
      row_start_q  <= 16'h0;
      row_end_q    <= ROW_END_RST;
      bl_q         <= 8'hFF;
      disp_q       <= 1'b0;
      ovf_q        <= 1'b0;
      fifo_we_q    <= 1'b0;
      fifo_di_q    <= 8'h00;
      frame_ctrl_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fifo_we_q    <= 1'b0;
      frame_ctrl_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (wr_evt && !rs_s) begin
        // A command always abandons whatever was in progress before it is decoded.
        state_q <= IDLE;
        pidx_q  <= 2'd0;
        pcmd_q  <= d_s;
        case (d_s)
          CMD_CASET, CMD_PASET, CMD_BL: state_q <= PARAM;
          CMD_DISPON:  disp_q <= 1'b1;
          CMD_DISPOFF: disp_q <= 1'b0;
          CMD_RAMWR: begin
            state_q      <= MEMWR;
            cnt_q        <= '0;
            frame_ctrl_q <= 1'b1;
            ovf_q        <= 1'b0;
          end
          CMD_RAMWRC: state_q <= MEMWR;
          CMD_SWRST: begin
            cnt_q       <= '0;
            pbuf_q      <= 24'h0;
            col_start_q <= 16'h0;
            col_end_q   <= COL_END_RST;
            row_start_q <= 16'h0;
            row_end_q   <= ROW_END_RST;
            bl_q        <= 8'hFF;
            disp_q      <= 1'b0;
            ovf_q       <= 1'b0;
            fifo_di_q   <= 8'h00;
          end
          default: state_q <= IGNORE;
        endcase
      end else if (wr_evt) begin
        case (state_q)
          PARAM: begin
            if (pidx_q == param_last(pcmd_q)) begin
              // Window pairs commit together on the final byte only.
              case (pcmd_q)
                CMD_CASET: begin
                  col_start_q <= pbuf_q[23:8];
                  col_end_q   <= {pbuf_q[7:0], d_s};
                end
                CMD_PASET: begin
                  row_start_q <= pbuf_q[23:8];
                  row_end_q   <= {pbuf_q[7:0], d_s};
                end
                default: bl_q <= d_s;
              endcase
              state_q <= IDLE;
            end else begin
              pbuf_q <= {pbuf_q[15:0], d_s};
              pidx_q <= pidx_q + 2'd1;
            end
          end
          MEMWR: begin
            if (FIFO_FULL) begin
              ovf_q <= 1'b1;
            end else begin
              fifo_we_q <= 1'b1;
              fifo_di_q <= d_s;
            end
            // Dropped bytes still advance the counter so the frame stays aligned.
            if (cnt_q == LAST_BYTE) begin
              cnt_q        <= '0;
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i8080_RD    = 1'b1;
  assign FIFO_WE     = fifo_we_q;
  assign FIFO_DI     = fifo_di_q;
  assign FrameCtrl   = frame_ctrl_q;
  assign FRAME_DONE  = frame_done_q;
  assign COL_START   = col_start_q;
  assign COL_END     = col_end_q;
  assign ROW_START   = row_start_q;
  assign ROW_END     = row_end_q;
  assign BL_LEVEL    = bl_q;
  assign DISP_ON     = disp_q;
  assign OVERFLOW    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i8080_rx_ctrl.sv
// Bench for i8080_rx_ctrl: a full-size instance and a 4x2 instance share one host bus and are
// checked against a byte-level behavioural model.
module tb_i8080_rx_ctrl;
  import i8080_pkg::*;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic       CS, RS, WR, FIFO_FULL;
  logic [7:0] D;

  logic        rd0, we0, fc0, fd0, disp0, ovf0;
  logic [7:0]  di0, bl0;
  logic [15:0] cs0, ce0, rs0, re0;
  state_t      st0;
  logic        rd1, we1, fc1, fd1, disp1, ovf1;
  logic [7:0]  di1, bl1;
  logic [15:0] cs1, ce1, rs1, re1;
  state_t      st1;

  i8080_rx_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RST(RST), .i8080_CS(CS), .i8080_RS(RS), .i8080_WR(WR), .i8080_D(D),
    .i8080_RD(rd0), .FIFO_FULL(FIFO_FULL), .FIFO_WE(we0), .FIFO_DI(di0), .FrameCtrl(fc0),
    .FRAME_DONE(fd0), .COL_START(cs0), .COL_END(ce0), .ROW_START(rs0), .ROW_END(re0),
    .BL_LEVEL(bl0), .DISP_ON(disp0), .OVERFLOW(ovf0), .dbg_state_o(st0)
  );

  i8080_rx_ctrl #(.SYNC_STAGES(SYNC), .H_RES(4), .V_RES(2), .BYTES_PER_PIX(2)) dut_s (
    .CLK(CLK), .RST(RST), .i8080_CS(CS), .i8080_RS(RS), .i8080_WR(WR), .i8080_D(D),
    .i8080_RD(rd1), .FIFO_FULL(FIFO_FULL), .FIFO_WE(we1), .FIFO_DI(di1), .FrameCtrl(fc1),
    .FRAME_DONE(fd1), .COL_START(cs1), .COL_END(ce1), .ROW_START(rs1), .ROW_END(re1),
    .BL_LEVEL(bl1), .DISP_ON(disp1), .OVERFLOW(ovf1), .dbg_state_o(st1)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_PARAM = 1, M_MEM = 2, M_IGN = 3;
  int          m_mode[2], m_need[2], m_got[2], m_cnt[2], m_total[2], m_hres[2], m_vres[2];
  int          m_starts[2], m_dones[2], m_pushes[2];
  logic [7:0]  m_pcmd[2], m_bl[2];
  logic [7:0]  m_buf[2][4];
  logic [15:0] m_cs[2], m_ce[2], m_rs[2], m_re[2];
  logic        m_disp[2], m_ovf[2];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  task automatic model_reset(input int i);
    m_mode[i] = M_IDLE; m_got[i] = 0; m_cnt[i] = 0;
    m_cs[i] = 16'd0; m_ce[i] = 16'(m_hres[i] - 1);
    m_rs[i] = 16'd0; m_re[i] = 16'(m_vres[i] - 1);
    m_bl[i] = 8'hFF; m_disp[i] = 1'b0; m_ovf[i] = 1'b0;
  endtask

  task automatic model_write(input logic cs_n, input logic rs, input logic [7:0] d,
                             input logic full, output logic exp_we0, output logic col_done0);
    exp_we0 = 1'b0;
    col_done0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (cs_n) continue;
      if (!rs) begin
        m_mode[i] = M_IDLE;
        m_got[i]  = 0;
        m_pcmd[i] = d;
        case (d)
          8'h2A, 8'h2B: begin m_mode[i] = M_PARAM; m_need[i] = 4; end
          8'h51: begin m_mode[i] = M_PARAM; m_need[i] = 1; end
          8'h29: m_disp[i] = 1'b1;
          8'h28: m_disp[i] = 1'b0;
          8'h2C: begin m_mode[i] = M_MEM; m_cnt[i] = 0; m_starts[i]++; m_ovf[i] = 1'b0; end
          8'h3C: m_mode[i] = M_MEM;
          8'h01: model_reset(i);
          default: m_mode[i] = M_IGN;
        endcase
      end else if (m_mode[i] == M_PARAM) begin
        m_buf[i][m_got[i]] = d;
        m_got[i]++;
        if (m_got[i] == m_need[i]) begin
          if (m_pcmd[i] == 8'h2A) begin
            m_cs[i] = {m_buf[i][0], m_buf[i][1]};
            m_ce[i] = {m_buf[i][2], m_buf[i][3]};
            if (i == 0) col_done0 = 1'b1;
          end else if (m_pcmd[i] == 8'h2B) begin
            m_rs[i] = {m_buf[i][0], m_buf[i][1]};
            m_re[i] = {m_buf[i][2], m_buf[i][3]};
          end else begin
            m_bl[i] = m_buf[i][0];
          end
          m_mode[i] = M_IDLE;
        end
      end else if (m_mode[i] == M_MEM) begin
        if (full) begin
          m_ovf[i] = 1'b1;
        end else begin
          m_pushes[i]++;
          if (i == 0) begin exp_q0.push_back(d); exp_we0 = 1'b1; end
          else exp_q1.push_back(d);
        end
        if (m_cnt[i] == m_total[i] - 1) begin
          m_dones[i]++; m_cnt[i] = 0; m_mode[i] = M_IDLE;
        end else begin
          m_cnt[i]++;
        end
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int we_cnt[2], fc_cnt[2], fd_cnt[2];

  always @(negedge CLK) begin
    if (!RST) begin
      if (we0) begin
        we_cnt[0]++;
        if (exp_q0.size() == 0) check("fifo0_unexpected_we", {24'h0, di0}, 32'hFFFF_FFFF);
        else check("fifo0_di", {24'h0, di0}, {24'h0, exp_q0.pop_front()});
      end
      if (we1) begin
        we_cnt[1]++;
        if (exp_q1.size() == 0) check("fifo1_unexpected_we", {24'h0, di1}, 32'hFFFF_FFFF);
        else check("fifo1_di", {24'h0, di1}, {24'h0, exp_q1.pop_front()});
      end
      if (fc0) fc_cnt[0]++;
      if (fc1) fc_cnt[1]++;
      if (fd0) fd_cnt[0]++;
      if (fd1) fd_cnt[1]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic check_regs();
    check("col_start", cs0, m_cs[0]);
    check("col_end",   ce0, m_ce[0]);
    check("row_start", rs0, m_rs[0]);
    check("row_end",   re0, m_re[0]);
    check("bl_level",  bl0, m_bl[0]);
    check("disp_on",   disp0, m_disp[0]);
    check("overflow",  ovf0, m_ovf[0]);
    check("rd_high",   rd0, 1'b1);
    check("s_col_end", ce1, m_ce[1]);
    check("s_overflow", ovf1, m_ovf[1]);
  endtask

  task automatic bus_write(input logic cs_n, input logic rs, input logic [7:0] d,
                           input logic full);
    logic        exp_we, col_done;
    logic [31:0] old_pair, new_pair;
    int          lat;
    CS = cs_n; RS = rs; D = d; FIFO_FULL = full; WR = 1'b0;
    idle($urandom_range(2, 4));
    old_pair = {cs0, ce0};
    WR = 1'b1;
    model_write(cs_n, rs, d, full, exp_we, col_done);
    new_pair = {m_cs[0], m_ce[0]};
    lat = -1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge CLK); #1;
      if (we0 && lat < 0) lat = k;
      if (col_done)
        check("caset_atomic", ({cs0, ce0} == old_pair) || ({cs0, ce0} == new_pair), 1'b1);
    end
    check(exp_we ? "we_latency" : "no_we", lat, exp_we ? LAT : -1);
    check_regs();
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    CS = 1'b1; WR = 1'b1; RS = 1'b0; D = 8'h00; FIFO_FULL = 1'b0;
    idle(2);
    check("rst_we", we0, 1'b0);
    check("rst_di", di0, 8'h00);
    check("rst_framectrl", fc0, 1'b0);
    check("rst_framedone", fd0, 1'b0);
    check("rst_col_end", ce0, 16'd799);
    check("rst_row_end", re0, 16'd479);
    check("rst_bl", bl0, 8'hFF);
    check("rst_state", st0, IDLE);
    check("rst_s_col_end", ce1, 16'd3);
    check("rst_s_row_end", re1, 16'd1);
    RST = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < 2; i++) model_reset(i);
    idle(2);
    check_regs();
  endtask

  task automatic check_counts(input string tag);
    idle(LAT + 2);
    check({tag, "_q0_empty"}, exp_q0.size(), 0);
    check({tag, "_q1_empty"}, exp_q1.size(), 0);
    check({tag, "_we0"}, we_cnt[0], m_pushes[0]);
    check({tag, "_we1"}, we_cnt[1], m_pushes[1]);
    check({tag, "_fc0"}, fc_cnt[0], m_starts[0]);
    check({tag, "_fd0"}, fd_cnt[0], m_dones[0]);
    check({tag, "_fd1"}, fd_cnt[1], m_dones[1]);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [7:0] CMD_LIST [8] = '{8'h2A, 8'h2B, 8'h2C, 8'h3C, 8'h51, 8'h29, 8'h28, 8'h01};

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base_we, n_full;
    logic [7:0] cmd;
    m_hres = '{800, 4};
    m_vres = '{480, 2};
    m_total = '{800 * 480 * 2, 16};
    m_starts = '{0, 0}; m_dones = '{0, 0}; m_pushes = '{0, 0};
    we_cnt = '{0, 0}; fc_cnt = '{0, 0}; fd_cnt = '{0, 0};
    for (int i = 0; i < 2; i++) model_reset(i);
    #1;
    apply_reset();
    idle(10);
    check("idle_no_we", we_cnt[0], 0);

    // Column window, then a window write cut short by a memory-write command.
    bus_write(0, 0, 8'h2A, 0);
    foreach (CMD_LIST[i]) if (i < 0) cmd = 0;
    bus_write(0, 1, 8'h00, 0); bus_write(0, 1, 8'h10, 0);
    bus_write(0, 1, 8'h01, 0); bus_write(0, 1, 8'h1F, 0);
    check("caset_start", cs0, 16'h0010);
    check("caset_end", ce0, 16'h011F);
    bus_write(0, 0, 8'h2A, 0);
    bus_write(0, 1, 8'h00, 0); bus_write(0, 1, 8'h55, 0);
    bus_write(0, 0, 8'h2C, 0);
    check("caset_abort_start", cs0, 16'h0010);
    check("caset_abort_end", ce0, 16'h011F);

    // Short memory write.
    bus_write(0, 1, 8'hAB, 0);
    bus_write(0, 1, 8'hCD, 0);
    check_counts("memwr");

    // Full small frame plus one extra byte.
    bus_write(0, 0, 8'h2C, 0);
    for (int i = 0; i < 17; i++) bus_write(0, 1, 8'($urandom_range(0, 255)), 0);
    check_counts("frame");
    check("frame_done_small", fd_cnt[1], 1);

    // Overflow: three of six bytes meet a full FIFO.
    bus_write(0, 0, 8'h2C, 0);
    base_we = we_cnt[0];
    for (int i = 0; i < 6; i++) bus_write(0, 1, 8'(8'h60 + i), (i % 2) == 0);
    FIFO_FULL = 1'b0;
    idle(LAT);
    check("ovf_we_pulses", we_cnt[0] - base_we, 3);
    check("ovf_set", ovf0, 1'b1);
    bus_write(0, 0, 8'h2C, 0);
    check("ovf_clear", ovf0, 1'b0);

    // Deselected writes, backlight, display on, then soft reset.
    bus_write(1, 0, 8'h51, 0);
    bus_write(1, 1, 8'h11, 0);
    bus_write(0, 0, 8'h51, 0);
    bus_write(0, 1, 8'h40, 0);
    bus_write(0, 0, 8'h29, 0);
    check("bl_40", bl0, 8'h40);
    check("disp_on_1", disp0, 1'b1);
    bus_write(0, 0, 8'h01, 0);
    check("swrst_bl", bl0, 8'hFF);
    check("swrst_disp", disp0, 1'b0);
    check_counts("directed");

    // Randomized traffic.
    for (int n = 0; n < 160; n++) begin
      logic c_n, r;
      c_n = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 9) > 1);
      if (r) cmd = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 5) == 0) cmd = 8'($urandom_range(0, 255));
      else cmd = CMD_LIST[$urandom_range(0, 7)];
      n_full = $urandom_range(0, 3);
      bus_write(c_n, r, cmd, n_full == 0);
    end
    FIFO_FULL = 1'b0;
    check_counts("random");

    // Reset with a pixel byte in flight: nothing may reach the FIFO.
    bus_write(0, 0, 8'h2C, 0);
    check_counts("pre_rst");
    base_we = we_cnt[0];
    CS = 1'b0; RS = 1'b1; D = 8'h5A; WR = 1'b0;
    idle(3);
    WR = 1'b1;
    idle(2);
    apply_reset();
    idle(8);
    check("rst_inflight_no_we", we_cnt[0], base_we);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
